spi_enc_dec_slave: RTL and testbench
====================================

Name: spi_enc_dec_slave

Overview:
- Slave end of the serial link driven by the existing master (Mosi out, Miso in, shared in_clk).
- Deserialises {message, key} from Mosi and hands them in parallel to the enc/dec core with a start pulse.
- Waits for the core result, then serialises it back on Miso, framed by data_done.
- Sits between the master and the AES enc/dec core.

Parameters:
- nk, 8: key length in 32-bit words (key width 32*nk).
- nb, 4: block length in 32-bit words (message/result width 32*nb).
- nr, 14: round count; sets the default WAIT timeout.
- TIMEOUT, 4*nr+16: max in_clk cycles in WAIT before abort (used only with the optional feature).

Ports:
- in_clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  1  select from master; high = Mosi frame in progress.
- Mosi  input  1  serial data from master, MSB first.
- Miso  output  1  serial result to master, MSB first.
- data_done  output  1  high exactly while Miso carries valid result bits.
- core_msg  output  32*nb  message to core.
- core_key  output  32*nk  key to core.
- core_start  output  1  one-cycle start pulse to core.
- core_result  input  32*nb  result from core.
- core_valid  input  1  core_result valid (single-cycle pulse or level).
- busy  output  1  high in any state except IDLE.
- timeout_err  output  1  only with SLAVE_TIMEOUT_EN; one-cycle abort pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE; Miso=0, data_done=0, core_start=0, busy=0, timeout_err=0; core_msg, core_key, shift registers and counters all 0.
- Frame length L=32*nb+32*nk (384 at defaults). Bit counter width is ceil(log2(L+1)).
- IDLE: on a posedge with cs=1, sample Mosi as frame bit 0 (MSB) and go to RECV with count=1.
- RECV: each posedge with cs=1, shift Mosi into the LSB of the L-bit shift register and increment count.
- On the edge where count reaches L, load core_msg = upper 32*nb bits and core_key = lower 32*nk bits, then go to START.
- cs=0 during RECV (count<L): discard the partial frame, clear count, return to IDLE. No core_start is issued.
- START: core_start=1 for exactly one cycle, then go to WAIT. Latency from the last Mosi bit to core_start=1 is 1 cycle.
- WAIT: on the first posedge with core_valid=1, capture core_result into the output shift register.
  - Same edge: drive Miso=result MSB and data_done=1; go to SEND with count=1.
  - core_valid is ignored in every other state.
- SEND: each posedge, shift left and drive the next bit on Miso.
  - After 32*nb bits have been presented (data_done high exactly 32*nb cycles), data_done=0, Miso=0, go to IDLE.
  - This guarantees the master, sampling Miso on posedge while data_done=1, captures exactly 32*nb bits MSB first.
- cs activity during START/WAIT/SEND is ignored. A new frame is accepted only from IDLE.
- cs high on the same edge SEND exits: not accepted until the next edge in IDLE.
- Miso is never high-Z; it is 0 whenever data_done=0.
- Reset asserted mid-operation: immediate return to the reset state; the partial frame and result are lost.

Optional Feature:
- Macro: SLAVE_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT.
  - If TIMEOUT cycles elapse with no core_valid, pulse timeout_err for 1 cycle and return to IDLE with data_done=0 and Miso=0.
  - core_valid on the same edge as expiry wins: the result is sent and no error is raised.
- Undefined: no watchdog and no timeout_err port. WAIT holds indefinitely.

Test Plan:
- FIPS-197 AES-256 frame: msg 00112233445566778899aabbccddeeff, key 000102…1e1f, sent over 384 cycles.
  - Required: core_msg/core_key equal those values, and core_start pulses 1 cycle after the last bit.
  - Core model returns 8ea2b7ca516745bfeafc49904b496089 after 20 cycles. Required: data_done high for exactly 128 cycles, and the bits sampled on Miso equal 8ea2b7ca…6089.
- cs dropped after 100 bits. Required: back in IDLE, no core_start, busy=0.
  - A following full frame with msg ffff…ff and key 0 loads correctly.
- rst pulled low at SEND bit 60. Required: Miso=0, data_done=0, busy=0 immediately (asynchronously).
  - After release, a new frame completes normally.
- cs toggled and random Mosi during WAIT. Required: core_msg/core_key unchanged, and the result is still sent once core_valid arrives.
- With SLAVE_TIMEOUT_EN and TIMEOUT=72, core never asserts core_valid. Required: timeout_err pulses at WAIT cycle 72, data_done never rises, state returns to IDLE.
- Back-to-back frames, cs reasserted the cycle after data_done falls. Required: second frame captured in full and both results returned in order.

Source files
------------

// File: rtl/spi_enc_dec_slave.sv
// spi_enc_dec_slave
//
// Slave end of the serial link to the enc/dec core. It shifts a
// {message, key} frame in from Mosi (MSB first) while cs is high, hands the
// frame to the core with a one-cycle start pulse, waits for the core result
// and then shifts the result out on Miso (MSB first), framed by data_done.
//
// Optional build macro: SLAVE_TIMEOUT_EN
//   When defined, a watchdog limits the time spent waiting for the core.
//   If TIMEOUT cycles pass without core_valid, timeout_err pulses for one
//   cycle and the slave returns to idle. The timeout_err port exists only in
//   that build.
//
// Ports
//   in_clk       clock, all logic on the rising edge
//   rst          asynchronous active-low reset
//   cs           frame select from the master, high while a frame is sent
//   Mosi         serial frame data from the master
//   Miso         serial result to the master, 0 whenever data_done is low
//   data_done    high exactly while Miso carries result bits
//   core_msg     message word handed to the core
//   core_key     key handed to the core
//   core_start   one-cycle start pulse to the core
//   core_result  result from the core
//   core_valid   core_result valid (pulse or level)
//   busy         high in every state except IDLE
//   timeout_err  watchdog abort pulse (SLAVE_TIMEOUT_EN only)
//
// state | meaning
// IDLE  | waiting for cs; first frame bit taken on the edge that leaves
// RECV  | shifting frame bits in
// START | core_start high for this one cycle
// WAIT  | waiting for core_valid (optionally bounded by the watchdog)
// SEND  | shifting the result out on Miso

module spi_enc_dec_slave #(
   parameter int nk      = 8,
   parameter int nb      = 4,
   parameter int nr      = 14,
   parameter int TIMEOUT = 4*nr+16
) (
   input  logic              in_clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              Mosi,
   output logic              Miso,
   output logic              data_done,
   output logic [32*nb-1:0]  core_msg,
   output logic [32*nk-1:0]  core_key,
   output logic              core_start,
   input  logic [32*nb-1:0]  core_result,
   input  logic              core_valid,
   output logic              busy
`ifdef SLAVE_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   localparam int MW = 32*nb;
   localparam int KW = 32*nk;
   localparam int L  = MW + KW;
   localparam int CW = $clog2(L+1);

   typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

   state_t          state, state_d;
   logic [L-2:0]    rx_sr;
   logic [L-1:0]    rx_next;
   logic [MW-1:0]   tx_sr;
   logic [CW-1:0]   count;
   logic            rx_last;
   logic            tx_last;
   logic            expire;
   logic            unused_params;

   // The shift register keeps only L-1 bits; the newest full frame is the
   // register plus the bit arriving on this edge.
   assign rx_next = {rx_sr, Mosi};
   assign rx_last = (count == CW'(L-1));
   assign tx_last = (count == CW'(MW));
   assign Miso    = tx_sr[MW-1];
   assign unused_params = ^{nr, TIMEOUT};

   always_comb begin
      state_d    = state;
      core_start = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE:  if (cs) state_d = RECV;
         RECV:  begin
            if (!cs)          state_d = IDLE;
            else if (rx_last) state_d = START;
         end
         START: begin
            core_start = 1'b1;
            state_d    = WAIT;
         end
         // core_valid wins over a watchdog expiry on the same edge
         WAIT:  begin
            if (core_valid)  state_d = SEND;
            else if (expire) state_d = IDLE;
         end
         SEND:  if (tx_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rx_sr     <= '0;
         tx_sr     <= '0;
         count     <= '0;
         core_msg  <= '0;
         core_key  <= '0;
         data_done <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            IDLE: begin
               if (cs) begin
                  rx_sr <= rx_next[L-2:0];
                  count <= CW'(1);
               end
            end
            RECV: begin
               if (!cs) begin
                  count <= '0;
               end else begin
                  rx_sr <= rx_next[L-2:0];
                  count <= count + CW'(1);
                  if (rx_last) begin
                     core_msg <= rx_next[L-1 -: MW];
                     core_key <= rx_next[KW-1:0];
                     count    <= '0;
                  end
               end
            end
            WAIT: begin
               if (core_valid) begin
                  tx_sr     <= core_result;
                  data_done <= 1'b1;
                  count     <= CW'(1);
               end
            end
            SEND: begin
               if (tx_last) begin
                  tx_sr     <= '0;
                  data_done <= 1'b0;
                  count     <= '0;
               end else begin
                  tx_sr <= tx_sr << 1;
                  count <= count + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SLAVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] wd;

   assign expire = (wd == '0);

   // Down-counter loaded while in START so it holds TIMEOUT-1 on the first
   // WAIT edge; the edge that sees zero is WAIT edge number TIMEOUT.
   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         if (state == START) begin
            wd <= TW'(TIMEOUT-1);
         end else if (state == WAIT && !core_valid) begin
            if (expire) timeout_err <= 1'b1;
            else        wd <= wd - TW'(1);
         end
      end
   end
`else
   assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_spi_enc_dec_slave.sv
// Testbench for spi_enc_dec_slave. Frames are issued by the stimulus process,
// which pushes the expected core inputs and result into queues; a monitor
// compares core_msg/core_key on every core_start and the Miso bit stream on
// every data_done burst. A behavioural core model answers core_start.

module tb_spi_enc_dec_slave;

   localparam int MW = 128;
   localparam int KW = 256;
   localparam int L  = MW + KW;
   localparam int TO = 4*14+16;

   localparam logic [MW-1:0] FIPS_MSG = 128'h00112233445566778899aabbccddeeff;
   localparam logic [KW-1:0] FIPS_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [MW-1:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic            in_clk = 1'b0;
   logic            rst, cs, Mosi, Miso, data_done, core_start, core_valid, busy;
   logic [MW-1:0]   core_msg, core_result;
   logic [KW-1:0]   core_key;
`ifdef SLAVE_TIMEOUT_EN
   logic            timeout_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [MW-1:0] exp_msg_q[$];
   logic [KW-1:0] exp_key_q[$];
   logic [MW-1:0] exp_res_q[$];

   int            core_delay = 20;
   logic [MW-1:0] core_r;

   int            rx_cnt = 0;
   logic [MW-1:0] rx_bits = '0;
   logic          prev_dd = 1'b0;
   int            miso_viol = 0;

   always #5 in_clk = ~in_clk;

   spi_enc_dec_slave dut (
      .in_clk      (in_clk),
      .rst         (rst),
      .cs          (cs),
      .Mosi        (Mosi),
      .Miso        (Miso),
      .data_done   (data_done),
      .core_msg    (core_msg),
      .core_key    (core_key),
      .core_start  (core_start),
      .core_result (core_result),
      .core_valid  (core_valid),
      .busy        (busy)
`ifdef SLAVE_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural core: the known AES-256 vector, otherwise an arbitrary
   // invertible mix of message and key so every bit matters.
   function automatic logic [MW-1:0] core_fn(input logic [MW-1:0] m, input logic [KW-1:0] k);
      if (m == FIPS_MSG && k == FIPS_KEY) return FIPS_CT;
      return ({m[63:0], m[127:64]} ^ k[255:128] ^ k[127:0]) + 128'd1;
   endfunction

   function automatic logic [MW-1:0] rnd_msg();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [KW-1:0] rnd_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a falling edge; returns at the falling edge right after the
   // rising edge that took the last bit, where core_start must already be high.
   task automatic send_frame(input logic [MW-1:0] m, input logic [KW-1:0] k, input bit want_res);
      logic [L-1:0] f;
      f = {m, k};
      exp_msg_q.push_back(m);
      exp_key_q.push_back(k);
      if (want_res) exp_res_q.push_back(core_fn(m, k));
      for (int i = L-1; i >= 0; i--) begin
         cs   = 1'b1;
         Mosi = f[i];
         @(negedge in_clk);
      end
      cs   = 1'b0;
      Mosi = 1'b0;
      chk("start_latency", core_start, 1);
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while ((busy || data_done) && n < maxc) begin
         @(negedge in_clk);
         n++;
      end
      chk("idle_reached", busy | data_done, 0);
   endtask

   // core model
   initial begin
      core_valid  = 1'b0;
      core_result = '0;
      forever begin
         @(negedge in_clk);
         if (core_start && core_delay > 0) begin
            core_r = core_fn(core_msg, core_key);
            repeat (core_delay) @(negedge in_clk);
            core_result = core_r;
            core_valid  = 1'b1;
            @(negedge in_clk);
            core_valid  = 1'b0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge in_clk);
         if (!rst) begin
            rx_cnt  = 0;
            prev_dd = 1'b0;
         end else begin
            if (!data_done && Miso) miso_viol++;
            if (core_start) begin
               if (exp_msg_q.size() == 0) begin
                  chk("unexpected_start", 1, 0);
               end else begin
                  chk("core_msg", core_msg, exp_msg_q.pop_front());
                  chk("core_key", core_key, exp_key_q.pop_front());
               end
            end
            if (data_done) begin
               rx_bits = {rx_bits[MW-2:0], Miso};
               rx_cnt++;
            end else if (prev_dd) begin
               chk("done_len", rx_cnt, MW);
               if (exp_res_q.size() == 0) chk("unexpected_result", 1, 0);
               else chk("result", rx_bits, exp_res_q.pop_front());
               rx_cnt = 0;
            end
            prev_dd = data_done;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [MW-1:0] m;
      logic [KW-1:0] k;
      int n;
      rst = 1'b1; cs = 1'b0; Mosi = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("rst_miso", Miso, 0);
      chk("rst_done", data_done, 0);
      chk("rst_start", core_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_msg", core_msg, 0);
      chk("rst_key", core_key, 0);
`ifdef SLAVE_TIMEOUT_EN
      chk("rst_tmo", timeout_err, 0);
`endif
      @(negedge in_clk);
      @(negedge in_clk);
      rst = 1'b1;
      @(negedge in_clk);

      // known AES-256 vector
      core_delay = 20;
      send_frame(FIPS_MSG, FIPS_KEY, 1);
      chk("fips_msg", core_msg, FIPS_MSG);
      chk("fips_key", core_key, FIPS_KEY);
      wait_idle(400);

      // frame aborted after 100 bits
      for (int i = 0; i < 100; i++) begin
         cs   = 1'b1;
         Mosi = 1'($urandom_range(0, 1));
         @(negedge in_clk);
      end
      cs = 1'b0;
      @(negedge in_clk);
      chk("abort_busy", busy, 0);
      chk("abort_start", core_start, 0);
      chk("abort_msg_kept", core_msg, FIPS_MSG);
      send_frame('1, '0, 1);
      chk("ones_msg", core_msg, {MW{1'b1}});
      chk("zero_key", core_key, 0);
      wait_idle(400);

      // reset during result transmission
      core_delay = int'($urandom_range(1, 30));
      send_frame(rnd_msg(), rnd_key(), 1);
      n = 0;
      while (!data_done && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      chk("send_started", data_done, 1);
      repeat (59) @(negedge in_clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_miso", Miso, 0);
      chk("midrst_done", data_done, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_msg", core_msg, 0);
      @(negedge in_clk);
      #2 rst = 1'b1;
      exp_res_q.delete();
      @(negedge in_clk);
      send_frame(rnd_msg(), rnd_key(), 1);
      wait_idle(400);

      // cs and Mosi activity while waiting for the core
      core_delay = 20;
      m = rnd_msg();
      k = rnd_key();
      send_frame(m, k, 1);
      for (int i = 0; i < 10; i++) begin
         cs   = 1'($urandom_range(0, 1));
         Mosi = 1'($urandom_range(0, 1));
         @(negedge in_clk);
      end
      cs = 1'b0;
      chk("noise_msg", core_msg, m);
      chk("noise_key", core_key, k);
      wait_idle(400);

      // back-to-back frames
      core_delay = 5;
      send_frame(rnd_msg(), rnd_key(), 1);
      n = 0;
      while (!data_done && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      n = 0;
      while (data_done && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      chk("b2b_first_done", data_done, 0);
      send_frame(rnd_msg(), rnd_key(), 1);
      wait_idle(400);

      // random frames with random core latency
      for (int i = 0; i < 4; i++) begin
         core_delay = int'($urandom_range(1, 40));
         send_frame(rnd_msg(), rnd_key(), 1);
         wait_idle(400);
      end

`ifdef SLAVE_TIMEOUT_EN
      // core never answers: watchdog abort
      begin
         int first, pulses;
         bit dd_seen;
         core_delay = -1;
         first = 0; pulses = 0; dd_seen = 1'b0;
         send_frame(rnd_msg(), rnd_key(), 0);
         for (int i = 1; i <= TO + 10; i++) begin
            @(negedge in_clk);
            if (timeout_err) begin
               pulses++;
               if (first == 0) first = i;
            end
            if (data_done) dd_seen = 1'b1;
         end
         // pulse follows the TO-th WAIT edge, one edge after the START cycle
         chk("tmo_when", first, TO + 1);
         chk("tmo_pulses", pulses, 1);
         chk("tmo_no_done", dd_seen, 0);
         chk("tmo_busy", busy, 0);
         core_delay = 20;
         send_frame(rnd_msg(), rnd_key(), 1);
         wait_idle(400);
      end
`endif

      repeat (3) @(negedge in_clk);
      chk("miso_zero_outside_done", miso_viol, 0);
      chk("pending_starts", exp_msg_q.size(), 0);
      chk("pending_results", exp_res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
